mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mem_access.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory stage of a simple pipeline. Non-memory ops pass their
// writeback through with one cycle of latency. Loads and stores are issued
// as a single bus request and held until ack, error or timeout. While the
// access is outstanding, stall_req_output is held high.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned halfword
// and word accesses with an err_output pulse. When it is undefined, the low
// address bits are dropped for lane selection and the access proceeds.
module mem_access #(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  aluop_input,
    input  logic [4:0]  wd_input,
    input  logic        wreg_input,
    input  logic [31:0] wdata_input,
    input  logic [31:0] mem_addr_input,
    input  logic [31:0] mem_store_data_input,
    output logic        bus_req_output,
    output logic        bus_we_output,
    output logic [31:0] bus_addr_output,
    output logic [3:0]  bus_sel_output,
    output logic [31:0] bus_wdata_output,
    input  logic [31:0] bus_rdata_input,
    input  logic        bus_ack_input,
    input  logic        bus_err_input,
    output logic [4:0]  wd_output,
    output logic        wreg_output,
    output logic [31:0] wdata_output,
    output logic        stall_req_output,
    output logic        err_output
);

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Last WAIT cycle index; no response in this cycle ends the access.
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUS_TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg, count_next;
    logic [7:0]  op_reg, op_next;
    logic [1:0]  off_reg, off_next;
    logic        load_reg, load_next;
    logic [4:0]  pend_wd_reg, pend_wd_next;

    logic        bus_req_reg, bus_req_next;
    logic        bus_we_reg, bus_we_next;
    logic [31:0] bus_addr_reg, bus_addr_next;
    logic [3:0]  bus_sel_reg, bus_sel_next;
    logic [31:0] bus_wdata_reg, bus_wdata_next;
    logic [4:0]  wd_reg, wd_next;
    logic        wreg_reg, wreg_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        stall_reg, stall_next;
    logic        err_reg, err_next;

    // Decode of the incoming request
    logic        req_mem;
    logic        req_store;
    logic [1:0]  req_size;
    logic [1:0]  req_off;
    logic [3:0]  req_sel;
    logic [31:0] req_wdata;
    logic        align_fault;

    // Read-data lane extraction
    logic [7:0]  rd_lane [4];
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_value;

    // Classify the opcode: memory or not, store or load, access size
    always_comb begin
        req_mem   = 1'b1;
        req_store = 1'b0;
        req_size  = SZ_WORD;
        case (aluop_input)
            OP_LB, OP_LBU: req_size = SZ_BYTE;
            OP_LH, OP_LHU: req_size = SZ_HALF;
            OP_LW:         req_size = SZ_WORD;
            OP_SB: begin
                req_store = 1'b1;
                req_size  = SZ_BYTE;
            end
            OP_SH: begin
                req_store = 1'b1;
                req_size  = SZ_HALF;
            end
            OP_SW:         req_store = 1'b1;
            default:       req_mem = 1'b0;
        endcase
    end

    // Aligned lane offset, big-endian byte enables and replicated store data
    always_comb begin
        req_off   = 2'b00;
        req_sel   = 4'b1111;
        req_wdata = mem_store_data_input;
        case (req_size)
            SZ_BYTE: begin
                req_off   = mem_addr_input[1:0];
                req_sel   = 4'b1000 >> mem_addr_input[1:0];
                req_wdata = {4{mem_store_data_input[7:0]}};
            end
            SZ_HALF: begin
                req_off   = {mem_addr_input[1], 1'b0};
                req_sel   = mem_addr_input[1] ? 4'b0011 : 4'b1100;
                req_wdata = {2{mem_store_data_input[15:0]}};
            end
            default: begin
                req_off   = 2'b00;
                req_sel   = 4'b1111;
                req_wdata = mem_store_data_input;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign align_fault = req_mem &&
                         (((req_size == SZ_HALF) && mem_addr_input[0]) ||
                          ((req_size == SZ_WORD) && (mem_addr_input[1:0] != 2'b00)));
`else
    assign align_fault = 1'b0;
`endif

    // Lane gi is the big-endian byte gi of the read word (lane 0 = MSB)
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_lane[gi] = bus_rdata_input[31 - 8*gi -: 8];
    end

    assign rd_byte = rd_lane[off_reg];
    assign rd_half = off_reg[1] ? bus_rdata_input[15:0] : bus_rdata_input[31:16];

    // Extend the selected lane according to the pending load type
    always_comb begin
        load_value = bus_rdata_input;
        case (op_reg)
            OP_LB:   load_value = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_value = {24'd0, rd_byte};
            OP_LH:   load_value = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_value = {16'd0, rd_half};
            default: load_value = bus_rdata_input;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        op_next        = op_reg;
        off_next       = off_reg;
        load_next      = load_reg;
        pend_wd_next   = pend_wd_reg;
        bus_req_next   = bus_req_reg;
        bus_we_next    = bus_we_reg;
        bus_addr_next  = bus_addr_reg;
        bus_sel_next   = bus_sel_reg;
        bus_wdata_next = bus_wdata_reg;
        wd_next        = wd_reg;
        wreg_next      = wreg_reg;
        wdata_next     = wdata_reg;
        stall_next     = stall_reg;
        err_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (align_fault) begin
                    wreg_next = 1'b0;
                    err_next  = 1'b1;
                end else if (req_mem) begin
                    state_next     = WAIT;
                    count_next     = 8'd0;
                    op_next        = aluop_input;
                    off_next       = req_off;
                    load_next      = !req_store;
                    pend_wd_next   = wd_input;
                    bus_req_next   = 1'b1;
                    bus_we_next    = req_store;
                    bus_addr_next  = mem_addr_input;
                    bus_sel_next   = req_sel;
                    bus_wdata_next = req_wdata;
                    wreg_next      = 1'b0;
                    stall_next     = 1'b1;
                end else begin
                    wd_next    = wd_input;
                    wreg_next  = wreg_input;
                    wdata_next = wdata_input;
                end
            end
            WAIT: begin
                if (bus_err_input || (!bus_ack_input && (count_reg == TIMEOUT_LAST))) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                    stall_next   = 1'b0;
                    wreg_next    = 1'b0;
                    err_next     = 1'b1;
                end else if (bus_ack_input) begin
                    state_next   = IDLE;
                    bus_req_next = 1'b0;
                    stall_next   = 1'b0;
                    if (load_reg) begin
                        wd_next    = pend_wd_reg;
                        wreg_next  = 1'b1;
                        wdata_next = load_value;
                    end else begin
                        wreg_next  = 1'b0;
                    end
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset overrides every other event
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= 8'd0;
            op_reg        <= 8'd0;
            off_reg       <= 2'd0;
            load_reg      <= 1'b0;
            pend_wd_reg   <= 5'd0;
            bus_req_reg   <= 1'b0;
            bus_we_reg    <= 1'b0;
            bus_addr_reg  <= 32'd0;
            bus_sel_reg   <= 4'd0;
            bus_wdata_reg <= 32'd0;
            wd_reg        <= 5'd0;
            wreg_reg      <= 1'b0;
            wdata_reg     <= 32'd0;
            stall_reg     <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            op_reg        <= op_next;
            off_reg       <= off_next;
            load_reg      <= load_next;
            pend_wd_reg   <= pend_wd_next;
            bus_req_reg   <= bus_req_next;
            bus_we_reg    <= bus_we_next;
            bus_addr_reg  <= bus_addr_next;
            bus_sel_reg   <= bus_sel_next;
            bus_wdata_reg <= bus_wdata_next;
            wd_reg        <= wd_next;
            wreg_reg      <= wreg_next;
            wdata_reg     <= wdata_next;
            stall_reg     <= stall_next;
            err_reg       <= err_next;
        end
    end

    assign bus_req_output   = bus_req_reg;
    assign bus_we_output    = bus_we_reg;
    assign bus_addr_output  = bus_addr_reg;
    assign bus_sel_output   = bus_sel_reg;
    assign bus_wdata_output = bus_wdata_reg;
    assign wd_output        = wd_reg;
    assign wreg_output      = wreg_reg;
    assign wdata_output     = wdata_reg;
    assign stall_req_output = stall_reg;
    assign err_output       = err_reg;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access. Stimulus is driven on the
// falling edge and outputs are sampled on the falling edge. Expected values
// come from an arithmetic model of the byte-lane and extension rules.
module tb_mem_access;

    localparam int TO = 4;

    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_NOP = 8'h00;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  aluop_input;
    logic [4:0]  wd_input;
    logic        wreg_input;
    logic [31:0] wdata_input;
    logic [31:0] mem_addr_input;
    logic [31:0] mem_store_data_input;
    logic        bus_req_output;
    logic        bus_we_output;
    logic [31:0] bus_addr_output;
    logic [3:0]  bus_sel_output;
    logic [31:0] bus_wdata_output;
    logic [31:0] bus_rdata_input;
    logic        bus_ack_input;
    logic        bus_err_input;
    logic [4:0]  wd_output;
    logic        wreg_output;
    logic [31:0] wdata_output;
    logic        stall_req_output;
    logic        err_output;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access #(.BUS_TIMEOUT(TO)) dut (
        .clock               (clock),
        .reset               (reset),
        .aluop_input         (aluop_input),
        .wd_input            (wd_input),
        .wreg_input          (wreg_input),
        .wdata_input         (wdata_input),
        .mem_addr_input      (mem_addr_input),
        .mem_store_data_input(mem_store_data_input),
        .bus_req_output      (bus_req_output),
        .bus_we_output       (bus_we_output),
        .bus_addr_output     (bus_addr_output),
        .bus_sel_output      (bus_sel_output),
        .bus_wdata_output    (bus_wdata_output),
        .bus_rdata_input     (bus_rdata_input),
        .bus_ack_input       (bus_ack_input),
        .bus_err_input       (bus_err_input),
        .wd_output           (wd_output),
        .wreg_output         (wreg_output),
        .wdata_output        (wdata_output),
        .stall_req_output    (stall_req_output),
        .err_output          (err_output)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic bit op_signed(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

    function automatic int aligned_off(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int a  = int'(addr % 4);
        return a - (a % sz);
    endfunction

    function automatic bit model_fault(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        return ALIGN_CHK && (sz > 1) && ((addr % sz) != 0);
    endfunction

    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int a  = aligned_off(op, addr);
        int m  = ((1 << sz) - 1) << (4 - a - sz);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [7:0] op, input logic [31:0] d);
        int sz = op_size(op);
        if (sz == 1) return {24'd0, d[7:0]} * 32'h01010101;
        if (sz == 2) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        int sz = op_size(op);
        int a  = aligned_off(op, addr);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v = (rdata >> (8 * (4 - a - sz))) & mask;
        if (op_signed(op) && v[8 * sz - 1]) v = v | ~mask;
        return v;
    endfunction

    // kind: 0 ack, 1 err, 2 ack+err together, 3 no response; k = WAIT cycle of response
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic [31:0] rdata, input int kind, input int k,
                          output logic [3:0] obs_sel, output logic [31:0] obs_bwdata,
                          output logic [31:0] obs_ldata, output int obs_stall);
        logic [36:0] e_bus;
        logic [68:0] got_bus;
        logic [31:0] e_load;
        bit ack_now, err_now;
        obs_sel    = 4'd0;
        obs_bwdata = 32'd0;
        obs_ldata  = 32'd0;
        obs_stall  = 0;
        e_load = model_load(op, addr, rdata);
        e_bus  = {op_store(op), model_sel(op, addr), model_wdata(op, sdata)};

        aluop_input = op;
        mem_addr_input = addr;
        mem_store_data_input = sdata;
        wd_input = wd;
        wreg_input = 1'b1;
        wdata_input = $urandom;
        bus_ack_input = 1'b0;
        bus_err_input = 1'b0;
        @(negedge clock);

        if (model_fault(op, addr)) begin
            n_checks++;
            if ({bus_req_output, stall_req_output, wreg_output, err_output} !== 4'b0001) begin
                n_fail++;
                $display("FAIL align_fault: req/stall/wreg/err got %b need 0001",
                         {bus_req_output, stall_req_output, wreg_output, err_output});
            end
            aluop_input = OP_NOP;
            wreg_input = 1'b0;
            @(negedge clock);
            n_checks++;
            if ({bus_req_output, err_output} !== 2'b00) begin
                n_fail++;
                $display("FAIL align_pulse: req/err got %b need 00", {bus_req_output, err_output});
            end
            $display("txn op=%h addr=%h alignment fault", op, addr);
            return;
        end

        obs_sel = bus_sel_output;
        obs_bwdata = bus_wdata_output;
        n_checks++;
        if ({bus_req_output, stall_req_output, wreg_output, err_output} !== 4'b1100) begin
            n_fail++;
            $display("FAIL issue_ctrl: req/stall/wreg/err got %b need 1100",
                     {bus_req_output, stall_req_output, wreg_output, err_output});
        end
        n_checks++;
        if ({bus_addr_output, bus_we_output, bus_sel_output, bus_wdata_output} !== {addr, e_bus}) begin
            n_fail++;
            $display("FAIL issue_bus: addr/we/sel/wdata got %h %b %b %h need %h %b %b %h",
                     bus_addr_output, bus_we_output, bus_sel_output, bus_wdata_output,
                     addr, e_bus[36], e_bus[35:32], e_bus[31:0]);
        end
        got_bus = {bus_addr_output, e_bus};

        // inputs other than the bus response must be ignored while waiting
        aluop_input = 8'($urandom);
        mem_addr_input = $urandom;
        mem_store_data_input = $urandom;
        wd_input = 5'($urandom);

        for (int c = 1; c <= TO; c++) begin
            if (stall_req_output === 1'b1) obs_stall++;
            if (c > 1) begin
                n_checks++;
                if ({bus_req_output, stall_req_output, wreg_output, err_output,
                     bus_addr_output, bus_we_output, bus_sel_output, bus_wdata_output}
                    !== {4'b1100, got_bus}) begin
                    n_fail++;
                    $display("FAIL wait_hold c=%0d: req/stall/wreg/err %b addr %h sel %b", c,
                             {bus_req_output, stall_req_output, wreg_output, err_output},
                             bus_addr_output, bus_sel_output);
                end
            end
            ack_now = ((kind == 0) || (kind == 2)) && (c == k);
            err_now = ((kind == 1) || (kind == 2)) && (c == k);
            bus_ack_input = ack_now;
            bus_err_input = err_now;
            bus_rdata_input = (ack_now || err_now) ? rdata : $urandom;
            if (ack_now || err_now || (c == TO)) begin
                @(negedge clock);
                bus_ack_input = 1'b0;
                bus_err_input = 1'b0;
                obs_ldata = wdata_output;
                n_checks++;
                if (err_now || !ack_now) begin
                    if ({bus_req_output, stall_req_output, wreg_output, err_output} !== 4'b0001) begin
                        n_fail++;
                        $display("FAIL abort: req/stall/wreg/err got %b need 0001",
                                 {bus_req_output, stall_req_output, wreg_output, err_output});
                    end
                end else if (op_store(op)) begin
                    if ({bus_req_output, stall_req_output, wreg_output, err_output} !== 4'b0000) begin
                        n_fail++;
                        $display("FAIL store_done: req/stall/wreg/err got %b need 0000",
                                 {bus_req_output, stall_req_output, wreg_output, err_output});
                    end
                end else begin
                    if ({bus_req_output, stall_req_output, wreg_output, err_output,
                         wd_output, wdata_output} !== {4'b0010, wd, e_load}) begin
                        n_fail++;
                        $display("FAIL load_done: ctrl %b wd %0d wdata %h need 0010 %0d %h",
                                 {bus_req_output, stall_req_output, wreg_output, err_output},
                                 wd_output, wdata_output, wd, e_load);
                    end
                end
                break;
            end
            @(negedge clock);
        end

        aluop_input = OP_NOP;
        wreg_input = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus_req_output, stall_req_output, wreg_output, err_output} !== 4'b0000) begin
            n_fail++;
            $display("FAIL after_txn: req/stall/wreg/err got %b need 0000",
                     {bus_req_output, stall_req_output, wreg_output, err_output});
        end
        $display("txn op=%h addr=%h kind=%0d k=%0d sel=%b result=%h", op, addr, kind, k,
                 obs_sel, obs_ldata);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        aluop_input = OP_LW;
        mem_addr_input = 32'h100;
        mem_store_data_input = $urandom;
        wd_input = 5'd7;
        wreg_input = 1'b1;
        wdata_input = $urandom;
        bus_rdata_input = $urandom;
        bus_ack_input = 1'b1;
        bus_err_input = 1'b1;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if ({bus_req_output, bus_we_output, bus_addr_output, bus_sel_output, bus_wdata_output,
             wd_output, wreg_output, wdata_output, stall_req_output, err_output} !== 110'd0) begin
            n_fail++;
            $display("FAIL reset_state: req %b addr %h wreg %b wdata %h stall %b err %b need all 0",
                     bus_req_output, bus_addr_output, wreg_output, wdata_output,
                     stall_req_output, err_output);
        end
        reset = 1'b0;
        bus_ack_input = 1'b0;
        bus_err_input = 1'b0;
        aluop_input = OP_NOP;
        wreg_input = 1'b0;
        @(negedge clock);
        $display("txn reset done");
    endtask

    task automatic test_passthrough(input int count);
        logic [7:0]  op;
        logic [4:0]  wd;
        logic        wr;
        logic [31:0] wdat;
        for (int i = 0; i < count; i++) begin
            if (i == 0) begin
                op = OP_OR; wd = 5'd5; wr = 1'b1; wdat = 32'h0000FFFF;
            end else begin
                op = 8'($urandom);
                if (op_size(op) != 0) op = OP_OR;
                wd = 5'($urandom); wr = 1'($urandom); wdat = $urandom;
            end
            aluop_input = op;
            wd_input = wd;
            wreg_input = wr;
            wdata_input = wdat;
            @(negedge clock);
            n_checks++;
            if ({wd_output, wreg_output, wdata_output, stall_req_output, bus_req_output, err_output}
                !== {wd, wr, wdat, 3'b000}) begin
                n_fail++;
                $display("FAIL passthrough i=%0d: wd %0d wreg %b wdata %h stall %b need %0d %b %h 0",
                         i, wd_output, wreg_output, wdata_output, stall_req_output, wd, wr, wdat);
            end
            $display("txn passthrough op=%h wd=%0d wreg=%b wdata=%h", op, wd, wr, wdat);
        end
        aluop_input = OP_NOP;
        wreg_input = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_scenarios();
        logic [3:0]  s;
        logic [31:0] bw, ld;
        int          st;
        do_mem(OP_LB, 32'h101, 32'h0, 5'd9, 32'h11802233, 0, 3, s, bw, ld, st);
        n_checks++;
        if ({s, ld} !== {4'b0100, 32'hFFFFFF80} || st != 3) begin
            n_fail++;
            $display("FAIL scen_lb: sel %b wdata %h stall_cycles %0d need 0100 ffffff80 3", s, ld, st);
        end
        do_mem(OP_SH, 32'h202, 32'hABCD1234, 5'd3, $urandom, 0, 1, s, bw, ld, st);
        n_checks++;
        if ({s, bw} !== {4'b0011, 32'h12341234}) begin
            n_fail++;
            $display("FAIL scen_sh: sel %b bus_wdata %h need 0011 12341234", s, bw);
        end
        do_mem(OP_LW, 32'h400, 32'h0, 5'd4, $urandom, 3, TO, s, bw, ld, st);
        n_checks++;
        if (st != TO) begin
            n_fail++;
            $display("FAIL scen_timeout: stall_cycles %0d need %0d", st, TO);
        end
        do_mem(OP_LHU, 32'h500, 32'h0, 5'd6, 32'hCAFEBEEF, 2, 2, s, bw, ld, st);
        do_mem(OP_LW, 32'h3, 32'h0, 5'd8, 32'h89ABCDEF, 0, 1, s, bw, ld, st);
        if (!ALIGN_CHK) begin
            n_checks++;
            if ({s, ld} !== {4'b1111, 32'h89ABCDEF}) begin
                n_fail++;
                $display("FAIL scen_misaligned_lw: sel %b wdata %h need 1111 89abcdef", s, ld);
            end
        end
        do_mem(OP_LH, 32'h7, 32'h0, 5'd2, 32'h8001FF7F, 0, 2, s, bw, ld, st);
    endtask

    task automatic test_reset_in_wait();
        aluop_input = OP_LW;
        mem_addr_input = 32'h600;
        wd_input = 5'd11;
        wreg_input = 1'b1;
        @(negedge clock);
        aluop_input = OP_NOP;
        wreg_input = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        bus_ack_input = 1'b1;
        bus_rdata_input = 32'h12345678;
        @(negedge clock);
        n_checks++;
        if ({bus_req_output, bus_we_output, bus_addr_output, bus_sel_output, bus_wdata_output,
             wd_output, wreg_output, wdata_output, stall_req_output, err_output} !== 110'd0) begin
            n_fail++;
            $display("FAIL reset_in_wait: req %b wreg %b wdata %h stall %b err %b need all 0",
                     bus_req_output, wreg_output, wdata_output, stall_req_output, err_output);
        end
        reset = 1'b0;
        bus_ack_input = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({bus_req_output, stall_req_output, wreg_output, err_output} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_no_err: req/stall/wreg/err got %b need 0000",
                     {bus_req_output, stall_req_output, wreg_output, err_output});
        end
        $display("txn reset during wait");
        test_passthrough(2);
    endtask

    task automatic test_random(input int count);
        logic [7:0]  ops [8];
        logic [7:0]  op;
        logic [3:0]  s;
        logic [31:0] bw, ld;
        int          st, r, kind;
        ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};
        for (int i = 0; i < count; i++) begin
            op = ops[$urandom_range(0, 7)];
            r = int'($urandom_range(0, 99));
            kind = (r < 60) ? 0 : (r < 75) ? 1 : (r < 85) ? 2 : 3;
            do_mem(op, $urandom, $urandom, 5'($urandom), $urandom, kind,
                   int'($urandom_range(1, TO)), s, bw, ld, st);
        end
    endtask

    initial begin
        reset = 1'b1;
        aluop_input = OP_NOP;
        wd_input = 5'd0;
        wreg_input = 1'b0;
        wdata_input = 32'd0;
        mem_addr_input = 32'd0;
        mem_store_data_input = 32'd0;
        bus_rdata_input = 32'd0;
        bus_ack_input = 1'b0;
        bus_err_input = 1'b0;
        @(negedge clock);
        test_reset();
        test_passthrough(8);
        test_scenarios();
        test_reset_in_wait();
        test_random(40);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
